// File: rtl/dbg_gpr_access_if.sv
// -----------------------------------------------------------------------------
// dbg_gpr_access_if
// Request/response channel between the debug module's abstract-command logic
// (master) and the GPR access sequencer (slave).
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both 1. Once valid is raised, the sender keeps valid
// and its payload stable until that edge. Ready may change freely and never
// depends on a transfer that has not yet happened.
//
// Signals:
//   dm_req_valid / dm_req_ready   request handshake
//   dm_req_write                  1 = write, 0 = read
//   dm_req_addr                   register index
//   dm_req_wdata                  write data
//   dm_req_postinc                response carries address+1 when set
//   dm_resp_valid / dm_resp_ready response handshake
//   dm_resp_rdata                 read data (0 for writes and errors)
//   dm_resp_err                   access failed
//   dm_resp_next_addr             address for autoincrement
// -----------------------------------------------------------------------------
interface dbg_gpr_access_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  dm_req_valid;
    logic                  dm_req_ready;
    logic                  dm_req_write;
    logic [ADDR_WIDTH-1:0] dm_req_addr;
    logic [DATA_WIDTH-1:0] dm_req_wdata;
    logic                  dm_req_postinc;
    logic                  dm_resp_valid;
    logic                  dm_resp_ready;
    logic [DATA_WIDTH-1:0] dm_resp_rdata;
    logic                  dm_resp_err;
    logic [ADDR_WIDTH-1:0] dm_resp_next_addr;

    modport master (
        output dm_req_valid, dm_req_write, dm_req_addr, dm_req_wdata,
               dm_req_postinc, dm_resp_ready,
        input  dm_req_ready, dm_resp_valid, dm_resp_rdata, dm_resp_err,
               dm_resp_next_addr
    );

    modport slave (
        input  dm_req_valid, dm_req_write, dm_req_addr, dm_req_wdata,
               dm_req_postinc, dm_resp_ready,
        output dm_req_ready, dm_resp_valid, dm_resp_rdata, dm_resp_err,
               dm_resp_next_addr
    );
endinterface

// File: rtl/dbg_gpr_access.sv
// -----------------------------------------------------------------------------
// dbg_gpr_access
// Debug-side sequencer for the register file's debug port. Takes one read or
// write request at a time, waits for the core to be halted (bounded by
// HALT_TIMEOUT), performs a single-cycle GPR access and returns a response.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   dm              request/response channel (slave side)
//   core_halted     core halted status
//   jtag_gpr_we     GPR write strobe (only ever high in the access cycle)
//   jtag_gpr_addr   GPR index (always the captured request address)
//   jtag_gpr_wdata  GPR write data (always the captured request data)
//   gpr_jtag_rdata  GPR read data, combinational from jtag_gpr_addr
//   o_dbg_state     current FSM state, for observation
// -----------------------------------------------------------------------------
module dbg_gpr_access #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int HALT_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dbg_gpr_access_if.slave       dm,
    input  logic                  core_halted,
    output logic                  jtag_gpr_we,
    output logic [ADDR_WIDTH-1:0] jtag_gpr_addr,
    output logic [DATA_WIDTH-1:0] jtag_gpr_wdata,
    input  logic [DATA_WIDTH-1:0] gpr_jtag_rdata,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HALT = 2'd1,
        ST_ACCESS    = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

    localparam logic [7:0] LP_TIMEOUT = HALT_TIMEOUT[7:0];

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_cnt;
    logic                  r_write_q;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [DATA_WIDTH-1:0] r_wdata_q;
    logic                  r_postinc_q;
    logic                  r_err_q;
    logic [DATA_WIDTH-1:0] r_rdata_q;

    logic                  w_req_ready;
    logic                  w_resp_valid;
    logic                  w_gpr_we;
    logic                  w_accept;
    logic                  w_cnt_inc;
    logic                  w_set_err;
    logic                  w_capture_rdata;

    // Next-state and output decode.
    always_comb begin
        w_state_next    = r_state;
        w_req_ready     = 1'b0;
        w_resp_valid    = 1'b0;
        w_gpr_we        = 1'b0;
        w_accept        = 1'b0;
        w_cnt_inc       = 1'b0;
        w_set_err       = 1'b0;
        w_capture_rdata = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (dm.dm_req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_WAIT_HALT;
                end
            end
            ST_WAIT_HALT: begin
                // Halt is checked before the timeout, so a halt seen in the
                // last allowed wait cycle still proceeds to the access.
                if (core_halted) begin
                    w_state_next = ST_ACCESS;
                end else if (r_cnt == LP_TIMEOUT) begin
                    w_set_err    = 1'b1;
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_ACCESS: begin
                // Halt is re-qualified here: if the core resumed, the write
                // strobe is suppressed and the access is reported as failed.
                w_gpr_we        = r_write_q & core_halted;
                w_capture_rdata = ~r_write_q & core_halted;
                w_set_err       = ~core_halted;
                w_state_next    = ST_RESP;
            end
            ST_RESP: begin
                w_resp_valid = 1'b1;
                if (dm.dm_resp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request capture, wait counter and response registers. rdata/err are
    // cleared on acceptance so a write or failed access reports rdata = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_write_q   <= 1'b0;
            r_addr_q    <= '0;
            r_wdata_q   <= '0;
            r_postinc_q <= 1'b0;
            r_err_q     <= 1'b0;
            r_rdata_q   <= '0;
        end else begin
            if (w_accept) begin
                r_cnt       <= '0;
                r_write_q   <= dm.dm_req_write;
                r_addr_q    <= dm.dm_req_addr;
                r_wdata_q   <= dm.dm_req_wdata;
                r_postinc_q <= dm.dm_req_postinc;
                r_err_q     <= 1'b0;
                r_rdata_q   <= '0;
            end
            if (w_cnt_inc) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_set_err) begin
                r_err_q <= 1'b1;
            end
            if (w_capture_rdata) begin
                r_rdata_q <= gpr_jtag_rdata;
            end
        end
    end

    assign dm.dm_req_ready      = w_req_ready;
    assign dm.dm_resp_valid     = w_resp_valid;
    // Response fields read as 0 whenever no response is being offered.
    assign dm.dm_resp_rdata     = w_resp_valid ? r_rdata_q : '0;
    assign dm.dm_resp_err       = w_resp_valid & r_err_q;
    assign dm.dm_resp_next_addr = w_resp_valid
                                  ? (r_addr_q + {{(ADDR_WIDTH-1){1'b0}}, r_postinc_q})
                                  : '0;

    assign jtag_gpr_we    = w_gpr_we;
    assign jtag_gpr_addr  = r_addr_q;
    assign jtag_gpr_wdata = r_wdata_q;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_dbg_gpr_access.sv
module tb_dbg_gpr_access;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TO = 255;

    typedef struct packed {
        logic [9:0]    resp_cycle;
        logic [1:0]    we_cnt;
        logic [9:0]    we_cycle;
        logic          err;
        logic [DW-1:0] rdata;
        logic [AW-1:0] next_addr;
    } txn_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          core_halted;
    logic          jtag_gpr_we;
    logic [AW-1:0] jtag_gpr_addr;
    logic [DW-1:0] jtag_gpr_wdata;
    logic [DW-1:0] gpr_jtag_rdata;
    logic [1:0]    dbg_state;

    dbg_gpr_access_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dm_if ();

    dbg_gpr_access #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HALT_TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dm             (dm_if.slave),
        .core_halted    (core_halted),
        .jtag_gpr_we    (jtag_gpr_we),
        .jtag_gpr_addr  (jtag_gpr_addr),
        .jtag_gpr_wdata (jtag_gpr_wdata),
        .gpr_jtag_rdata (gpr_jtag_rdata),
        .o_dbg_state    (dbg_state)
    );

    // ---------------- GPR file environment ----------------
    logic [DW-1:0] gpr_mem [32];
    logic          mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 32; i++) gpr_mem[i] <= '0;
        end else if (jtag_gpr_we && jtag_gpr_addr != '0) begin
            gpr_mem[jtag_gpr_addr] <= jtag_gpr_wdata;
        end
    end
    assign gpr_jtag_rdata = (jtag_gpr_addr == '0) ? '0 : gpr_mem[jtag_gpr_addr];

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    function automatic string fmt_txn(input txn_t t);
        return $sformatf("resp_cyc=%0d we_cnt=%0d we_cyc=%0d err=%0b rdata=%h next=%0d",
                         t.resp_cycle, t.we_cnt, t.we_cycle, t.err, t.rdata, t.next_addr);
    endfunction

    // ---------------- driver tasks ----------------
    // Entered just after a rising edge with the DUT idle; returns just after
    // the edge that accepted the request.
    task automatic drive_req(input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic p);
        dm_if.dm_req_valid   = 1'b1;
        dm_if.dm_req_write   = w;
        dm_if.dm_req_addr    = a;
        dm_if.dm_req_wdata   = d;
        dm_if.dm_req_postinc = p;
        @(posedge clk); #1;
        dm_if.dm_req_valid   = 1'b0;
    endtask

    // Cycle c = 1 is the first cycle after acceptance. core_halted is high in
    // cycle c when halt_from > 0, c >= halt_from and c != drop_at. Returns at
    // the falling edge of the first cycle showing resp_valid (resp_cycle = 0
    // if the budget runs out).
    task automatic run_cycles(input int halt_from, input int drop_at, input int budget,
                              output int we_cnt, output int we_cycle, output int resp_cycle);
        we_cnt = 0; we_cycle = 0; resp_cycle = 0;
        for (int c = 1; c <= budget; c++) begin
            core_halted = (halt_from > 0) && (c >= halt_from) && (c != drop_at);
            @(negedge clk);
            if (jtag_gpr_we) begin we_cnt++; we_cycle = c; end
            if (dm_if.dm_resp_valid) begin resp_cycle = c; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic finish_resp();
        dm_if.dm_resp_ready = 1'b1;
        @(posedge clk); #1;
        dm_if.dm_resp_ready = 1'b0;
    endtask

    // Computes the expected outcome from the halt schedule, runs the
    // transaction and returns both observed and expected records.
    task automatic do_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic p, input int halt_from, input int drop_at,
                          output txn_t obs, output txn_t exp);
        int acc, wc, wcy, rc;
        logic wr_ok;
        logic [DW-1:0] er;
        acc = 0;
        for (int c = 1; c <= TO + 1; c++) begin
            if (halt_from > 0 && c >= halt_from && c != drop_at) begin
                acc = c + 1;
                break;
            end
        end
        exp = '0;
        wr_ok = 1'b0;
        er = '0;
        if (acc == 0) begin
            exp.resp_cycle = 10'(TO + 2);
            exp.err = 1'b1;
        end else begin
            exp.resp_cycle = 10'(acc + 1);
            if (acc >= halt_from && acc != drop_at) begin
                wr_ok = w;
                er = w ? '0 : ((a == '0) ? '0 : ref_mem[a]);
            end else begin
                exp.err = 1'b1;
            end
        end
        exp.we_cnt    = wr_ok ? 2'd1 : 2'd0;
        exp.we_cycle  = wr_ok ? 10'(acc) : 10'd0;
        exp.next_addr = a + AW'(p);
        exp_q.push_back(er);

        drive_req(w, a, d, p);
        run_cycles(halt_from, drop_at, TO + 40, wc, wcy, rc);
        obs.resp_cycle = 10'(rc);
        obs.we_cnt     = (wc > 3) ? 2'd3 : 2'(wc);
        obs.we_cycle   = 10'(wcy);
        obs.err        = dm_if.dm_resp_err;
        obs.rdata      = dm_if.dm_resp_rdata;
        obs.next_addr  = dm_if.dm_resp_next_addr;
        exp.rdata      = exp_q.pop_front();
        finish_resp();
        if (wr_ok && a != '0) ref_mem[a] = d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [2*DW+2*AW+4-1:0] got;
        @(negedge clk);
        got = {jtag_gpr_we, dm_if.dm_req_ready, dm_if.dm_resp_valid, dm_if.dm_resp_err,
               dm_if.dm_resp_rdata, dm_if.dm_resp_next_addr, jtag_gpr_addr, jtag_gpr_wdata};
        total++;
        if (got !== {1'b0, 1'b1, 1'b0, 1'b0, {DW{1'b0}}, {AW{1'b0}}, {AW{1'b0}}, {DW{1'b0}}}) begin
            bad++;
            $display("FAIL reset_outputs: got %h, want ready=1 and all else 0", got);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_clear = 1'b0;
        @(negedge clk);
        total++;
        if ({dm_if.dm_req_ready, dm_if.dm_resp_valid, jtag_gpr_we} !== 3'b100) begin
            bad++;
            $display("FAIL reset_release: ready/valid/we=%b want 100",
                     {dm_if.dm_req_ready, dm_if.dm_resp_valid, jtag_gpr_we});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        txn_t obs, exp;
        do_txn(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1, -1, obs, exp);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL basic_write: %s want %s", fmt_txn(obs), fmt_txn(exp)); end
        do_txn(1'b0, 5'd5, 32'h0, 1'b0, 1, -1, obs, exp);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL basic_read: %s want %s", fmt_txn(obs), fmt_txn(exp)); end
        total++;
        if (obs.rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_read_value: got %h want deadbeef", obs.rdata); end
        do_txn(1'b1, 5'd0, 32'h12345678, 1'b0, 1, -1, obs, exp);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL write_r0: %s want %s", fmt_txn(obs), fmt_txn(exp)); end
        do_txn(1'b0, 5'd0, 32'h0, 1'b0, 1, -1, obs, exp);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL read_r0: %s want %s", fmt_txn(obs), fmt_txn(exp)); end
    endtask

    task automatic test_postinc();
        txn_t obs, exp;
        do_txn(1'b0, 5'd31, 32'h0, 1'b1, 1, -1, obs, exp);
        total++;
        if (obs.next_addr !== 5'd0 || obs !== exp) begin
            bad++; $display("FAIL postinc_wrap: %s want %s", fmt_txn(obs), fmt_txn(exp));
        end
        do_txn(1'b0, 5'd7, 32'h0, 1'b0, 1, -1, obs, exp);
        total++;
        if (obs.next_addr !== 5'd7 || obs !== exp) begin
            bad++; $display("FAIL postinc_off: %s want %s", fmt_txn(obs), fmt_txn(exp));
        end
    endtask

    task automatic test_timeout();
        txn_t obs, exp;
        do_txn(1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 0, -1, obs, exp);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL halt_timeout: %s want %s", fmt_txn(obs), fmt_txn(exp)); end
        do_txn(1'b1, 5'd13, 32'hA5A5A5A5, 1'b0, TO + 1, -1, obs, exp);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL halt_last_cycle: %s want %s", fmt_txn(obs), fmt_txn(exp)); end
        do_txn(1'b0, 5'd12, 32'h0, 1'b0, 1, -1, obs, exp);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL timeout_no_write: %s want %s", fmt_txn(obs), fmt_txn(exp)); end
    endtask

    task automatic test_late_halt();
        txn_t obs, exp;
        do_txn(1'b1, 5'd20, 32'h0BADF00D, 1'b0, 10, -1, obs, exp);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL late_halt: %s want %s", fmt_txn(obs), fmt_txn(exp)); end
        do_txn(1'b1, 5'd20, 32'h11112222, 1'b0, 1, 2, obs, exp);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL halt_drop_access: %s want %s", fmt_txn(obs), fmt_txn(exp)); end
        do_txn(1'b0, 5'd20, 32'h0, 1'b1, 1, -1, obs, exp);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL after_drop_read: %s want %s", fmt_txn(obs), fmt_txn(exp)); end
    endtask

    task automatic test_backpressure();
        int wc, wcy, rc;
        logic [DW-1:0] er;
        txn_t obs, exp;
        er = ref_mem[5];
        drive_req(1'b0, 5'd5, 32'h0, 1'b1);
        run_cycles(1, -1, 20, wc, wcy, rc);
        total++;
        if (rc != 3) begin bad++; $display("FAIL bp_latency: got %0d want 3", rc); end
        // A competing request is held valid while the response is stalled.
        dm_if.dm_req_valid   = 1'b1;
        dm_if.dm_req_write   = 1'b1;
        dm_if.dm_req_addr    = 5'd9;
        dm_if.dm_req_wdata   = 32'h99990009;
        dm_if.dm_req_postinc = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            total++;
            if ({dm_if.dm_resp_valid, dm_if.dm_req_ready, dm_if.dm_resp_rdata, dm_if.dm_resp_next_addr, jtag_gpr_we}
                !== {1'b1, 1'b0, er, 5'd6, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b rdata=%h next=%0d we=%b want 1 0 %h 6 0",
                         k, dm_if.dm_resp_valid, dm_if.dm_req_ready, dm_if.dm_resp_rdata,
                         dm_if.dm_resp_next_addr, jtag_gpr_we, er);
            end
        end
        finish_resp();
        @(negedge clk);
        total++;
        if ({dm_if.dm_req_ready, dm_if.dm_resp_valid} !== 2'b10) begin
            bad++; $display("FAIL bp_release: ready/valid=%b want 10", {dm_if.dm_req_ready, dm_if.dm_resp_valid});
        end
        @(posedge clk); #1;
        dm_if.dm_req_valid = 1'b0;
        run_cycles(1, -1, 20, wc, wcy, rc);
        total++;
        if (rc != 3 || wc != 1 || wcy != 2) begin
            bad++; $display("FAIL bp_next_req: resp_cyc=%0d we_cnt=%0d we_cyc=%0d want 3 1 2", rc, wc, wcy);
        end
        finish_resp();
        ref_mem[9] = 32'h99990009;
        do_txn(1'b0, 5'd9, 32'h0, 1'b0, 1, -1, obs, exp);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL bp_readback: %s want %s", fmt_txn(obs), fmt_txn(exp)); end
    endtask

    task automatic test_reset_mid();
        logic [2*DW+2*AW+4-1:0] got;
        txn_t obs, exp;
        drive_req(1'b1, 5'd3, 32'hFEEDFACE, 1'b0);
        core_halted = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (jtag_gpr_we !== 1'b1) begin bad++; $display("FAIL rst_mid_access: we=%b want 1", jtag_gpr_we); end
        #1 rst_n = 1'b0;
        #1;
        got = {jtag_gpr_we, dm_if.dm_req_ready, dm_if.dm_resp_valid, dm_if.dm_resp_err,
               dm_if.dm_resp_rdata, dm_if.dm_resp_next_addr, jtag_gpr_addr, jtag_gpr_wdata};
        total++;
        if (got !== {1'b0, 1'b1, 1'b0, 1'b0, {DW{1'b0}}, {AW{1'b0}}, {AW{1'b0}}, {DW{1'b0}}}) begin
            bad++;
            $display("FAIL rst_mid_outputs: got %h, want ready=1 and all else 0", got);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({dm_if.dm_req_ready, dm_if.dm_resp_valid} !== 2'b10) begin
            bad++; $display("FAIL rst_mid_idle: ready/valid=%b want 10", {dm_if.dm_req_ready, dm_if.dm_resp_valid});
        end
        @(posedge clk); #1;
        do_txn(1'b0, 5'd3, 32'h0, 1'b0, 1, -1, obs, exp);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rst_mid_no_write: %s want %s", fmt_txn(obs), fmt_txn(exp)); end
    endtask

    task automatic test_random();
        txn_t obs, exp;
        logic w, p;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int hf, dr;
        for (int n = 0; n < 40; n++) begin
            w  = 1'($urandom_range(0, 1));
            p  = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, 31));
            d  = $urandom;
            hf = $urandom_range(1, 4);
            dr = ($urandom_range(0, 7) == 0) ? hf + 1 : -1;
            do_txn(w, a, d, p, hf, dr, obs, exp);
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL random%0d: %s want %s", n, fmt_txn(obs), fmt_txn(exp));
            end
        end
    endtask

    initial begin
        dm_if.dm_req_valid   = 1'b0;
        dm_if.dm_req_write   = 1'b0;
        dm_if.dm_req_addr    = '0;
        dm_if.dm_req_wdata   = '0;
        dm_if.dm_req_postinc = 1'b0;
        dm_if.dm_resp_ready  = 1'b0;
        core_halted = 1'b0;
        mem_clear   = 1'b1;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_postinc();
        test_timeout();
        test_late_halt();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
